// File: rtl/cfg_sequencer_if.sv
// Host-side write/clear handshake and the byte stream toward the unit's cfg_in.
// The master modport is the host/front-end side; the slave modport is the sequencer.
interface cfg_sequencer_if;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    logic              wr_valid;
    logic              wr_ready;
    logic              wr_out_sel;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              clr_req;
    logic              busy;
    logic              clr_done;
    logic [DATA_W-1:0] cfg_out;

    modport master (
        output wr_valid, wr_out_sel, wr_addr, wr_data, clr_req,
        input  wr_ready, busy, clr_done, cfg_out
    );

    modport slave (
        input  wr_valid, wr_out_sel, wr_addr, wr_data, clr_req,
        output wr_ready, busy, clr_done, cfg_out
    );
endinterface

// File: rtl/cfg_sequencer.sv
// Serialises host config writes and bulk clears into the unit's two-byte
// command/data cfg_in protocol.
module cfg_sequencer #(
    parameter logic [7:0] CLR_FILL = 8'h00,
    parameter logic [7:0] OUT_FILL = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    cfg_sequencer_if.slave   bus
);
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] OSEL_CMD = 8'h7F;
    localparam logic [CNT_W-1:0]  CNT_LAST = 7'h7F;

    typedef enum logic [2:0] {
        IDLE, CMD, DATA, CLR_CMD, CLR_DATA, CLR_OCMD, CLR_ODATA
    } state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic                clr_pend, clr_pend_n;
    logic [BYTE_W-1:0]   cfg_q, cfg_n;
    logic [BYTE_W-1:0]   data_q, data_n;
    logic                done_q, done_n;
    logic                ready;
    logic                accept;
    logic                clr_want;

    // A clear request (new or pending) blocks new writes; rst_n gates ready low in reset.
    assign ready    = rst_n && (state == IDLE || state == DATA) && !clr_pend && !bus.clr_req;
    assign accept   = bus.wr_valid && ready;
    assign clr_want = clr_pend || bus.clr_req;

    assign bus.wr_ready = ready;
    assign bus.busy     = (state != IDLE) || clr_pend;
    assign bus.clr_done = done_q;
    assign bus.cfg_out  = cfg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            clr_pend <= 1'b0;
            cfg_q    <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            clr_pend <= clr_pend_n;
            cfg_q    <= cfg_n;
            data_q   <= data_n;
            done_q   <= done_n;
        end
    end

    // cfg_n is the byte that will be on cfg_out while in state_n.
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        clr_pend_n = clr_pend || bus.clr_req;
        cfg_n      = '0;
        data_n     = data_q;
        done_n     = 1'b0;

        unique case (state)
            IDLE, DATA: begin
                if (accept) begin
                    state_n = CMD;
                    cfg_n   = bus.wr_out_sel ? OSEL_CMD : {1'b1, bus.wr_addr};
                    data_n  = bus.wr_data;
                end else if (clr_want) begin
                    // Write boundary: start the clear and consume the request.
                    state_n    = CLR_CMD;
                    cnt_n      = '0;
                    clr_pend_n = 1'b0;
                    cfg_n      = {1'b1, CNT_W'(0)};
                end else begin
                    state_n = IDLE;
                end
            end
            CMD: begin
                state_n = DATA;
                cfg_n   = data_q;
            end
            CLR_CMD: begin
                state_n = CLR_DATA;
                cfg_n   = CLR_FILL;
            end
            CLR_DATA: begin
                cnt_n = CNT_W'(cnt + CNT_W'(1));
                if (cnt == CNT_LAST) begin
                    state_n = CLR_OCMD;
                    cfg_n   = OSEL_CMD;
                end else begin
                    state_n = CLR_CMD;
                    cfg_n   = {1'b1, cnt_n};
                end
            end
            CLR_OCMD: begin
                state_n = CLR_ODATA;
                cfg_n   = OUT_FILL;
            end
            CLR_ODATA: begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end
endmodule
